// File: rtl/inst_encoder_pkg.sv
// Shared constants, format codes and the instruction encode function for inst_encoder.
// The encoder is purely combinational; range errors are reported alongside the truncated word.
package inst_encoder_pkg;

  localparam int XLEN  = 32;
  localparam int FMT_W = 3;
  localparam int OPC_W = 7;
  localparam int REG_W = 5;
  localparam int F3_W  = 3;
  localparam int F7_W  = 7;

  localparam logic [FMT_W-1:0] FMT_R = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J = 3'd5;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic            err;
  } enc_t;

  // True when v, read as two's complement, fits in a signed field of 'bits' bits.
  function automatic logic fits_signed(input logic [XLEN-1:0] v, input int bits);
    logic [XLEN-1:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  function automatic enc_t encode(
    input logic [FMT_W-1:0] fmt,
    input logic [OPC_W-1:0] opc,
    input logic [REG_W-1:0] rd,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2,
    input logic [F3_W-1:0]  f3,
    input logic [F7_W-1:0]  f7,
    input logic [XLEN-1:0]  imm
  );
    enc_t e;
    e.word = NOP_WORD;
    e.err  = 1'b0;
    case (fmt)
      FMT_R: e.word = {f7, rs2, rs1, f3, rd, opc};
      FMT_I: begin
        e.word = {imm[11:0], rs1, f3, rd, opc};
        e.err  = !fits_signed(imm, 12);
      end
      FMT_S: begin
        e.word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
        e.err  = !fits_signed(imm, 12);
      end
      FMT_B: begin
        e.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
        e.err  = !fits_signed(imm, 13) || imm[0];
      end
      FMT_U: begin
        e.word = {imm[31:12], rd, opc};
        e.err  = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        e.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
        e.err  = !fits_signed(imm, 21) || imm[0];
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/inst_fifo2.sv
// Two-entry FIFO holding encoded words between acceptance and the memory write.
// Push is honoured when not full or when a pop happens in the same cycle.
module inst_fifo2 #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Accepts instruction records, encodes them and streams the words to memory at consecutive addresses.
// Latency 1 from acceptance to mem_we; in_ready drops while the 2-entry FIFO is full.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [XLEN-1:0]  base_addr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FMT_W-1:0] in_fmt,
  input  logic [OPC_W-1:0] in_opcode,
  input  logic [REG_W-1:0] in_rd,
  input  logic [REG_W-1:0] in_rs1,
  input  logic [REG_W-1:0] in_rs2,
  input  logic [F3_W-1:0]  in_func3,
  input  logic [F7_W-1:0]  in_func7,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_last,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e          state_q;
  logic [XLEN-1:0] addr_q;
  logic            err_q;
  logic            busy_q;
  logic            done_q;
  logic            fifo_empty;
  logic            fifo_full;
  logic            accept;
  logic            wr_done;
  enc_t            enc;

  assign enc = encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_func7, in_imm);

  // in_ready depends only on registered state so mem_ready never reaches it combinationally.
  assign in_ready  = (state_q == ST_RUN) && !fifo_full;
  assign accept    = in_valid && in_ready;
  assign mem_we    = !fifo_empty;
  assign wr_done   = mem_we && mem_ready;
  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  inst_fifo2 #(.W(XLEN)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .data_i  (enc.word),
    .pop_i   (wr_done),
    .data_o  (mem_wdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_done) addr_q <= addr_q + 32'd4;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            addr_q  <= base_addr;
            err_q   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (accept && enc.err) err_q <= 1'b1;
          if (accept && in_last) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // An empty FIFO means no write is outstanding.
          if (fifo_empty) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder with hand-computed instruction words and addresses.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_func3;
  logic [6:0]  in_func7;
  logic [31:0] in_imm;
  logic        in_last;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic        busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_func3(in_func3),
    .in_func7(in_func7), .in_imm(in_imm), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_rec(input logic [2:0] fmt, input logic [6:0] opc, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm, input logic last);
    in_fmt = fmt; in_opcode = opc; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_func3 = f3; in_func7 = f7; in_imm = imm; in_last = last; in_valid = 1'b1;
  endtask

  // Holds the current record valid until accepted (bounded), then drops in_valid.
  task automatic send(input string tag);
    logic ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) begin
        step();
        ok = 1'b1;
        break;
      end
      step();
    end
    in_valid = 1'b0;
    check({tag, "_accepted"}, {31'd0, ok}, 32'd1);
  endtask

  // Expects the next memory write; mem_ready must already be 1.
  task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    for (int c = 0; c < 20; c++) begin
      if (mem_we) break;
      step();
    end
    check({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    check({tag, "_addr"}, mem_addr, a);
    check({tag, "_data"}, mem_wdata, d);
    step();
  endtask

  task automatic wait_done(input string tag);
    for (int c = 0; c < 20; c++) begin
      if (done) break;
      step();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    step();
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic burst_rec(input int i);
    case (i)
      0: set_rec(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 1'b0);
      1: set_rec(3'd0, 7'h33, 5'd4, 5'd3, 5'd2, 3'd0, 7'h20, 32'd0, 1'b0);
      2: set_rec(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 1'b0);
      default: set_rec(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8, 1'b1);
    endcase
  endtask

  logic [31:0] exp_w [4];
  logic [31:0] got_a [$];
  logic [31:0] got_d [$];

  initial begin
    int idx;
    logic wr, acc;
    exp_w[0] = 32'h002081B3;
    exp_w[1] = 32'h40218233;
    exp_w[2] = 32'hFFF00293;
    exp_w[3] = 32'h0020A423;

    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; mem_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_func3 = '0; in_func7 = '0; in_imm = '0; in_last = 1'b0;
    step(); step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Single I record, latency and done sequencing.
    base_addr = 32'h100; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    set_rec(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 1'b1);
    step();
    in_valid = 1'b0;
    check("t1_we_lat1", {31'd0, mem_we}, 32'd1);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_data", mem_wdata, 32'h00500093);
    check("t1_drain_rdy", {31'd0, in_ready}, 32'd0);
    mem_ready = 1'b1;
    step();
    check("t1_we_after", {31'd0, mem_we}, 32'd0);
    check("t1_addr_inc", mem_addr, 32'h104);
    check("t1_no_done_yet", {31'd0, done}, 32'd0);
    step();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_busy_done", {31'd0, busy}, 32'd1);
    check("t1_err", {31'd0, err}, 32'd0);
    step();
    check("t1_done_pulse", {31'd0, done}, 32'd0);
    check("t1_idle", {31'd0, busy}, 32'd0);

    // B in/out of range, then J and U.
    mem_ready = 1'b0; base_addr = 32'h200; start = 1'b1;
    step();
    start = 1'b0;
    set_rec(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'hFFFF_FFF8, 1'b0);
    send("t2_b0");
    check("t2_b0_data", mem_wdata, 32'hFE209CE3);
    check("t2_b0_err", {31'd0, err}, 32'd0);
    set_rec(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'd3, 1'b0);
    send("t2_b1");
    check("t2_b1_err", {31'd0, err}, 32'd1);
    check("t2_full_rdy", {31'd0, in_ready}, 32'd0);
    mem_ready = 1'b1;
    check_write("t2_w0", 32'h200, 32'hFE209CE3);
    check_write("t2_w1", 32'h204, 32'h00209163);
    set_rec(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 1'b0);
    send("t2_j");
    check_write("t2_wj", 32'h208, 32'h001000EF);
    set_rec(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b1);
    send("t2_u");
    check_write("t2_wu", 32'h20C, 32'h123452B7);
    wait_done("t2");
    check("t2_err_sticky", {31'd0, err}, 32'd1);

    // Four-record burst with memory stalled.
    mem_ready = 1'b0; base_addr = 32'h300; start = 1'b1;
    step();
    start = 1'b0;
    check("t3_err_cleared", {31'd0, err}, 32'd0);
    burst_rec(0); step();
    burst_rec(1); step();
    check("t3_rdy_full", {31'd0, in_ready}, 32'd0);
    check("t3_we", {31'd0, mem_we}, 32'd1);
    burst_rec(2);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_stall_rdy", {31'd0, in_ready}, 32'd0);
      check("t3_stall_data", mem_wdata, exp_w[0]);
      check("t3_stall_addr", mem_addr, 32'h300);
    end
    mem_ready = 1'b1;
    idx = 2;
    for (int c = 0; c < 40; c++) begin
      if (got_d.size() >= 4) break;
      wr  = mem_we && mem_ready;
      acc = in_valid && in_ready;
      if (wr) begin
        got_a.push_back(mem_addr);
        got_d.push_back(mem_wdata);
      end
      step();
      if (acc) begin
        idx++;
        if (idx < 4) burst_rec(idx);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("t3_nwrites", got_d.size(), 32'd4);
    for (int i = 0; i < got_d.size() && i < 4; i++) begin
      check("t3_addr", got_a[i], 32'h300 + 32'(4 * i));
      check("t3_data", got_d[i], exp_w[i]);
    end
    wait_done("t3");
    check("t3_err", {31'd0, err}, 32'd0);

    // Address wrap.
    base_addr = 32'hFFFF_FFFC; start = 1'b1;
    step();
    start = 1'b0;
    set_rec(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 1'b0);
    send("t4_r0");
    check_write("t4_w0", 32'hFFFF_FFFC, 32'h00500093);
    set_rec(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 1'b1);
    send("t4_r1");
    check_write("t4_w1", 32'h0, 32'h123452B7);
    wait_done("t4");

    // Reset during DRAIN, then a fresh load with an undefined format.
    mem_ready = 1'b0; base_addr = 32'h400; start = 1'b1;
    step();
    start = 1'b0;
    set_rec(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5, 1'b1);
    send("t5_r0");
    check("t5_drain_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    step();
    check("t5_rst_we", {31'd0, mem_we}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_addr", mem_addr, 32'd0);
    rst_n = 1'b1; mem_ready = 1'b1;
    step(); step();
    check("t5_no_write", {31'd0, mem_we}, 32'd0);
    base_addr = 32'h500; start = 1'b1;
    step();
    start = 1'b0;
    check("t5_restart_rdy", {31'd0, in_ready}, 32'd1);
    set_rec(3'd7, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0, 1'b1);
    send("t5_bad");
    check("t5_bad_err", {31'd0, err}, 32'd1);
    check_write("t5_nop", 32'h500, 32'h00000013);
    wait_done("t5");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port start  input  1  begin a program load; sampled only in IDLE.
REQ-004 SHALL have port base_addr  input  32  first write address, latched on start.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1), a valid/ready handshake for one instruction record.
REQ-006 SHALL have record fields as inputs: in_fmt (3, format R/I/S/B/U/J), in_opcode (7), in_rd, in_rs1 and in_rs2 (5 each), in_func3 (3), in_func7 (7), in_imm (32, byte offset or full value), and in_last (1, final record).
REQ-007 SHALL have memory outputs mem_we (1), mem_addr (32) and mem_wdata (32), and input mem_ready (1); a write completes when mem_we and mem_ready are both 1.
REQ-008 SHALL have status outputs busy (1, not IDLE), done (1, one-cycle pulse) and err (1, sticky immediate-range error).

Function
REQ-009 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-010 SHALL go IDLE->RUN on start; RUN->DRAIN when a record with in_last=1 is accepted; DRAIN->DONE when the FIFO is empty and no write is pending; DONE->IDLE after exactly one cycle.
REQ-011 SHALL ignore start outside IDLE; start in IDLE clears err and loads the address counter with base_addr.
REQ-012 SHALL drive in_ready=1 only in RUN while the FIFO has a free entry; a record is accepted when in_valid and in_ready are both 1.
REQ-013 SHALL encode a record combinationally on acceptance and push it into a 2-entry FIFO in the same cycle; mem_we is first asserted the cycle after acceptance (latency 1).
REQ-014 SHALL encode R format as {func7,rs2,rs1,func3,rd,opcode}.
REQ-015 SHALL encode I format as {imm[11:0],rs1,func3,rd,opcode}.
REQ-016 SHALL encode S format as {imm[11:5],rs2,rs1,func3,imm[4:0],opcode}.
REQ-017 SHALL encode B format as {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],opcode}.
REQ-018 SHALL encode U format as {imm[31:12],rd,opcode}.
REQ-019 SHALL encode J format as {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-020 SHALL emit 32'h00000013 (NOP) for an undefined in_fmt and set err.
REQ-021 SHALL set err when the immediate is out of range: I/S outside signed 12 bits; B outside signed 13 bits or imm[0]!=0; J outside signed 21 bits or imm[0]!=0; U with imm[11:0]!=0. The truncated word is still written.
REQ-022 SHALL drive mem_we=1 whenever the FIFO is non-empty; mem_wdata and mem_addr SHALL stay stable until the write completes.
REQ-023 SHALL pop the FIFO and add 4 to the address on each completed write; the address SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 0).
REQ-024 SHALL allow a push and a pop in the same cycle when the FIFO is full, with in_ready=0 in that cycle.
REQ-025 SHALL assert done in the DONE cycle only; busy SHALL be 1 in RUN, DRAIN and DONE.

Reset
REQ-026 SHALL, with rst_n=0 at a clock edge, set state=IDLE, empty the FIFO, clear the address counter, and drive in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0 and err=0.
REQ-027 SHALL discard any in-flight records on reset mid-load, with no further write after the reset edge.

Structure
REQ-028 SHALL take the format codes (R=0, I=1, S=2, B=3, U=4, J=5), the NOP constant and the widths from the shared include file alongside the existing opcode and field-width defines.
REQ-029 SHALL implement the FIFO as the sub-module inst_fifo2 (2 entries of 64 bits: addr+data optional, data mandatory).

Verification
REQ-030 SHALL cover: start with base_addr=0x100; I record opcode=0x13, rd=1, rs1=0, func3=0, imm=5, in_last=1 -> write of 0x00500093 at 0x100, then done pulse, err=0.
REQ-031 SHALL cover: B record opcode=0x63, rs1=1, rs2=2, func3=1, imm=-8 -> 0xFE209CE3; the same record with imm=3 -> err=1.
REQ-032 SHALL cover: J record opcode=0x6F, rd=1, imm=2048 -> 0x001000EF; U record opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-033 SHALL cover: mem_ready held at 0 for 5 cycles during a 4-record burst -> in_ready drops after 2 accepts, data is held stable, and all 4 words land at consecutive addresses.
REQ-034 SHALL cover: base_addr=0xFFFFFFFC with 2 records -> writes at 0xFFFFFFFC then 0x0.
REQ-035 SHALL cover: rst_n=0 during DRAIN -> mem_we=0 on the next cycle, state IDLE, and start accepted afterwards.
